// File: rtl/pipe_pe_ui_acc_reduce.sv
// Streaming reduction PE: sums each group of LEN unsigned elements (or a flushed partial group)
// and hands the sum downstream through a single-entry valid/ready result register.
module pipe_pe_ui_acc_reduce #(
  parameter int unsigned N   = 64,
  parameter int unsigned LEN = 16,
  parameter int unsigned CW  = $clog2(LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trigger,
  output logic          cts,
  input  logic [N-1:0]  in,
  input  logic          flush,
  output logic [N-1:0]  out,
  output logic [CW-1:0] out_cnt,
  output logic          out_ovf,
  output logic          out_valid,
  input  logic          out_ready
);

  logic [N-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [N-1:0]  out_q, out_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          out_ovf_q, out_ovf_d;
  logic          out_valid_q, out_valid_d;

  logic          cnt_zero, cnt_last, accept, flush_eff, close;
  logic [N:0]    sum;
  logic [N-1:0]  fin_sum;
  logic [CW-1:0] fin_cnt;
  logic          fin_ovf;

  assign cnt_zero = (cnt_q == '0);
  assign cnt_last = (cnt_q == CW'(LEN - 1));

  // Stall only when a completing sum would land on an unconsumed result.
  assign cts       = ~(out_valid_q & ~out_ready & (cnt_last | flush));
  assign accept    = trigger & cts;
  assign flush_eff = flush & cts;
  assign close     = (accept & cnt_last) | (flush_eff & (~cnt_zero | accept));

  always_comb begin
    sum     = {1'b0, (cnt_zero ? {N{1'b0}} : acc_q)} + {1'b0, in};
    fin_sum = acc_q;
    fin_cnt = cnt_q;
    fin_ovf = ovf_q;
    if (accept) begin
      fin_sum = sum[N-1:0];
      fin_cnt = cnt_q + CW'(1);
      fin_ovf = (cnt_zero ? 1'b0 : ovf_q) | sum[N];
    end

    acc_d       = fin_sum;
    cnt_d       = fin_cnt;
    ovf_d       = fin_ovf;
    out_d       = out_q;
    out_cnt_d   = out_cnt_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    if (close) begin
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_d       = fin_sum;
      out_cnt_d   = fin_cnt;
      out_ovf_d   = fin_ovf;
      out_valid_d = 1'b1;
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_q       <= '0;
      out_cnt_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_q       <= out_d;
      out_cnt_q   <= out_cnt_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_cnt   = out_cnt_q;
  assign out_ovf   = out_ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pipe_pe_ui_acc_reduce.sv
// Directed bench for pipe_pe_ui_acc_reduce: an N=8/LEN=4 instance for the directed cases and
// an N=16/LEN=2 instance for the back-to-back random stream.
module tb_pipe_pe_ui_acc_reduce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: N=8, LEN=4
  logic       rst_a, trig_a, cts_a, flush_a, ovf_a, valid_a, ready_a;
  logic [7:0] in_a, out_a;
  logic [2:0] cnt_a;

  pipe_pe_ui_acc_reduce #(.N(8), .LEN(4)) dut_a (
    .clk(clk), .rst(rst_a), .trigger(trig_a), .cts(cts_a), .in(in_a), .flush(flush_a),
    .out(out_a), .out_cnt(cnt_a), .out_ovf(ovf_a), .out_valid(valid_a), .out_ready(ready_a)
  );

  // Instance B: N=16, LEN=2
  logic        rst_b, trig_b, cts_b, flush_b, ovf_b, valid_b, ready_b;
  logic [15:0] in_b, out_b;
  logic [1:0]  cnt_b;

  pipe_pe_ui_acc_reduce #(.N(16), .LEN(2)) dut_b (
    .clk(clk), .rst(rst_b), .trigger(trig_b), .cts(cts_b), .in(in_b), .flush(flush_b),
    .out(out_b), .out_cnt(cnt_b), .out_ovf(ovf_b), .out_valid(valid_b), .out_ready(ready_b)
  );

  // Apply inputs at the falling edge; outputs are sampled 1 time unit later.
  task automatic drv_a(input logic t, input logic [7:0] d, input logic f, input logic r);
    @(negedge clk);
    trig_a = t; in_a = d; flush_a = f; ready_a = r;
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    trig_a = 1'b0; in_a = '0; flush_a = 1'b0; ready_a = 1'b1;
    trig_b = 1'b0; in_b = '0; flush_b = 1'b0; ready_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    checks++;
    if ({valid_a, out_a, cnt_a, ovf_a} !== 13'd0) begin
      failures++;
      $display("FAIL reset_a: valid=%b out=%0d cnt=%0d ovf=%b, required all 0", valid_a, out_a, cnt_a, ovf_a);
    end
    checks++;
    if ({valid_b, out_b, cnt_b, ovf_b} !== 20'd0) begin
      failures++;
      $display("FAIL reset_b: valid=%b out=%0d cnt=%0d ovf=%b, required all 0", valid_b, out_b, cnt_b, ovf_b);
    end
    checks++;
    if (cts_a !== 1'b1) begin
      failures++;
      $display("FAIL reset_cts: cts=%b required 1", cts_a);
    end
  endtask

  task automatic test_sum;
    drv_a(1, 8'd1, 0, 1); drv_a(1, 8'd2, 0, 1); drv_a(1, 8'd3, 0, 1); drv_a(1, 8'd4, 0, 1);
    checks++;
    if (valid_a !== 1'b0) begin
      failures++;
      $display("FAIL sum_latency: valid=%b required 0 before closing edge", valid_a);
    end
    drv_a(0, 8'd0, 0, 1);
    checks++;
    if ({valid_a, out_a, cnt_a, ovf_a} !== {1'b1, 8'd10, 3'd4, 1'b0}) begin
      failures++;
      $display("FAIL sum_1234: valid=%b out=%0d cnt=%0d ovf=%b, required 1/10/4/0", valid_a, out_a, cnt_a, ovf_a);
    end
    drv_a(0, 8'd0, 0, 1);
    checks++;
    if (valid_a !== 1'b0) begin
      failures++;
      $display("FAIL sum_drain: valid=%b required 0", valid_a);
    end
  endtask

  task automatic test_wrap;
    drv_a(1, 8'd200, 0, 1); drv_a(1, 8'd100, 0, 1); drv_a(1, 8'd1, 0, 1); drv_a(1, 8'd1, 0, 1);
    drv_a(1, 8'd1, 0, 1);
    checks++;
    if ({valid_a, out_a, cnt_a, ovf_a} !== {1'b1, 8'd46, 3'd4, 1'b1}) begin
      failures++;
      $display("FAIL wrap_ovf: valid=%b out=%0d cnt=%0d ovf=%b, required 1/46/4/1", valid_a, out_a, cnt_a, ovf_a);
    end
    drv_a(1, 8'd1, 0, 1); drv_a(1, 8'd1, 0, 1); drv_a(1, 8'd1, 0, 1);
    drv_a(0, 8'd0, 0, 1);
    checks++;
    if ({valid_a, out_a, cnt_a, ovf_a} !== {1'b1, 8'd4, 3'd4, 1'b0}) begin
      failures++;
      $display("FAIL wrap_clear: valid=%b out=%0d cnt=%0d ovf=%b, required 1/4/4/0", valid_a, out_a, cnt_a, ovf_a);
    end
    drv_a(0, 8'd0, 0, 1);
  endtask

  task automatic test_backpressure;
    drv_a(1, 8'd1, 0, 0); drv_a(1, 8'd2, 0, 0); drv_a(1, 8'd3, 0, 0); drv_a(1, 8'd4, 0, 0);
    for (int k = 5; k <= 7; k++) begin
      drv_a(1, 8'(k), 0, 0);
      checks++;
      if ({valid_a, out_a, cnt_a} !== {1'b1, 8'd10, 3'd4} || cts_a !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold_%0d: valid=%b out=%0d cnt=%0d cts=%b, required 1/10/4 cts=1", k, valid_a, out_a, cnt_a, cts_a);
      end
    end
    drv_a(1, 8'd8, 0, 0);
    checks++;
    if (cts_a !== 1'b0 || out_a !== 8'd10) begin
      failures++;
      $display("FAIL bp_stall: cts=%b out=%0d, required cts=0 out=10", cts_a, out_a);
    end
    drv_a(1, 8'd8, 0, 0);
    checks++;
    if (cts_a !== 1'b0 || out_a !== 8'd10 || valid_a !== 1'b1) begin
      failures++;
      $display("FAIL bp_stall2: cts=%b out=%0d valid=%b, required 0/10/1", cts_a, out_a, valid_a);
    end
    drv_a(1, 8'd8, 0, 1);
    checks++;
    if (cts_a !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_cts: cts=%b required 1", cts_a);
    end
    drv_a(0, 8'd0, 0, 0);
    checks++;
    if ({valid_a, out_a, cnt_a, ovf_a} !== {1'b1, 8'd26, 3'd4, 1'b0}) begin
      failures++;
      $display("FAIL bp_second: valid=%b out=%0d cnt=%0d ovf=%b, required 1/26/4/0", valid_a, out_a, cnt_a, ovf_a);
    end
    drv_a(0, 8'd0, 0, 1);
    drv_a(0, 8'd0, 0, 1);
  endtask

  task automatic test_flush;
    drv_a(1, 8'd5, 0, 1); drv_a(1, 8'd7, 0, 1); drv_a(0, 8'd0, 1, 1);
    drv_a(0, 8'd0, 0, 1);
    checks++;
    if ({valid_a, out_a, cnt_a, ovf_a} !== {1'b1, 8'd12, 3'd2, 1'b0}) begin
      failures++;
      $display("FAIL flush_partial: valid=%b out=%0d cnt=%0d ovf=%b, required 1/12/2/0", valid_a, out_a, cnt_a, ovf_a);
    end
    drv_a(0, 8'd0, 0, 1);
    drv_a(0, 8'd0, 1, 1);
    drv_a(0, 8'd0, 0, 1);
    checks++;
    if (valid_a !== 1'b0) begin
      failures++;
      $display("FAIL flush_empty: valid=%b required 0", valid_a);
    end
    drv_a(1, 8'd9, 1, 1);
    drv_a(0, 8'd0, 0, 1);
    checks++;
    if ({valid_a, out_a, cnt_a, ovf_a} !== {1'b1, 8'd9, 3'd1, 1'b0}) begin
      failures++;
      $display("FAIL flush_accept: valid=%b out=%0d cnt=%0d ovf=%b, required 1/9/1/0", valid_a, out_a, cnt_a, ovf_a);
    end
    drv_a(0, 8'd0, 0, 1);
  endtask

  task automatic test_reset_mid;
    drv_a(1, 8'd3, 0, 0); drv_a(1, 8'd3, 0, 0); drv_a(1, 8'd3, 0, 0); drv_a(1, 8'd3, 0, 0);
    drv_a(1, 8'd2, 0, 0); drv_a(1, 8'd2, 0, 0);
    @(negedge clk);
    trig_a = 1'b0; rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    checks++;
    if (valid_a !== 1'b0 || out_a !== 8'd0) begin
      failures++;
      $display("FAIL rst_mid: valid=%b out=%0d, required 0/0", valid_a, out_a);
    end
    drv_a(1, 8'd1, 0, 1); drv_a(1, 8'd1, 0, 1); drv_a(1, 8'd1, 0, 1); drv_a(1, 8'd1, 0, 1);
    drv_a(0, 8'd0, 0, 1);
    checks++;
    if ({valid_a, out_a, cnt_a, ovf_a} !== {1'b1, 8'd4, 3'd4, 1'b0}) begin
      failures++;
      $display("FAIL rst_fresh: valid=%b out=%0d cnt=%0d ovf=%b, required 1/4/4/0", valid_a, out_a, cnt_a, ovf_a);
    end
  endtask

  task automatic test_back_to_back;
    logic [16:0] exp_q[$];
    logic [15:0] first;
    logic [16:0] s, e;
    int got = 0;
    int bad = 0;
    int cts_bad = 0;
    ready_b = 1'b1;
    for (int i = 0; i < 1000 + 4; i++) begin
      @(negedge clk);
      if (i < 1000) begin
        trig_b = 1'b1;
        in_b   = 16'($urandom_range(0, 65535));
        if (i % 2 == 0) first = in_b;
        else begin
          s = {1'b0, first} + {1'b0, in_b};
          exp_q.push_back(s);
        end
      end else begin
        trig_b = 1'b0;
        in_b   = '0;
      end
      #1;
      if (i < 1000 && cts_b !== 1'b1) cts_bad++;
      if (valid_b === 1'b1) begin
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra: unexpected result out=%0d", out_b);
        end else begin
          e = exp_q.pop_front();
          got++;
          if (out_b !== e[15:0] || ovf_b !== e[16] || cnt_b !== 2'd2) begin
            bad++;
            if (bad < 5)
              $display("FAIL b2b_result_%0d: out=%0d ovf=%b cnt=%0d, required %0d/%b/2",
                       got, out_b, ovf_b, cnt_b, e[15:0], e[16]);
          end
        end
      end
    end
    checks++;
    if (cts_bad != 0) begin
      failures++;
      $display("FAIL b2b_cts: %0d cycles with cts=0, required 0", cts_bad);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL b2b_data: %0d wrong results, required 0", bad);
    end
    checks++;
    if (got != 500 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_count: received %0d results (%0d left), required 500", got, exp_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_sum;
    test_wrap;
    test_backpressure;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
